pooled_map_serializer: RTL and testbench
========================================

# pooled_map_serializer

Receive-side companion to the conv/pooling layer. Accepts per-kernel pooled pixels arriving on shared processing-element lanes, stores one complete feature map per kernel, then streams all maps out as a single valid/ready pixel stream, channel-major then raster order. This is the format the next layer's convolution buffer expects. It sits between one conv/pooling layer and the input of the next.

## Interface
- BitSize, 32, pixel word width
- NumberOfK, 4, kernels (channels) per layer
- ProcessingElements, 2, data lanes; kernel i is carried on lane i % ProcessingElements
- OutWidth, 2, pooled map width and height; Depth = OutWidth*OutWidth words per channel
- clk  in  1  sole clock, rising edge
- res  in  1  reset, asynchronous, active-high
- in_valid  in  NumberOfK  per-kernel write strobe
- in_data  in  ProcessingElements×BitSize  lane data
- in_ready  out  1  high in COLLECT; low in DRAIN
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  BitSize  output pixel
- out_channel  out  $clog2(NumberOfK)  channel of current word
- out_last  out  1  high with final word of final channel
- out_done  out  1  one-cycle pulse after final transfer
- out_error  out  1  sticky protocol-violation flag

## Operation
- States: COLLECT (reset state) and DRAIN.
- COLLECT: for each i with in_valid[i]=1, write in_data[i % ProcessingElements] into bank i at wr_ptr[i], then increment wr_ptr[i]. Banks write independently, and several banks may write in one cycle.
- Lane conflict: two asserted in_valid bits that map to the same lane in one cycle set out_error. Both writes still occur with that lane's data.
- Writing to a bank whose wr_ptr == Depth sets out_error. The write is dropped and the pointer holds.
- COLLECT -> DRAIN on the clock edge where every wr_ptr equals Depth, counting writes made that cycle.
- DRAIN: rd_ch and rd_px start at 0. out_data = bank[rd_ch][rd_px] and out_channel = rd_ch. out_valid stays high for the whole state.
- A transfer occurs when out_valid and out_ready are both high. rd_px increments; on wrap from Depth-1 to 0, rd_ch increments.
- out_last = (rd_ch == NumberOfK-1) && (rd_px == Depth-1).
- A transfer with out_last high returns the block to COLLECT. The same edge clears all wr_ptr, rd_ch and rd_px, and out_done is high for the following cycle.
- in_valid seen while in_ready=0 sets out_error. Data is dropped.
- Arithmetic: pointers are $clog2(Depth+1) bits. Data passes unmodified, with no width change.
- Reset, including mid-operation: state=COLLECT, all pointers 0, out_valid=0, out_last=0, out_done=0, out_error=0, out_channel=0. out_data is don't-care, driven 0. Bank contents are not cleared.
- out_error clears only on reset.

## Timing
- Final write accepted at cycle N. At N+1: state=DRAIN, in_ready=0, out_valid=1 with channel 0, pixel 0.
- Throughput: one word per cycle while out_ready=1. out_data and out_channel hold stable while out_valid=1 and out_ready=0.
- Minimum drain: NumberOfK*Depth cycles.
- Last transfer at cycle M. At M+1: out_valid=0, out_done=1, in_ready=1. At M+2: out_done=0.
- in_valid at M+1 is accepted into the fresh maps.
- No combinational path from in_valid to out_valid.
- out_data and out_last are combinational from the registered pointers and array, so there is no bubble.

## Structure
- Shared package pms_pkg: state enum (COLLECT, DRAIN) and the pointer width function.
- Sub-module map_bank: one per kernel, generated NumberOfK times. Holds Depth×BitSize storage, write pointer, full flag, overflow detect, and an asynchronous read port.
- Top level contains the FSM, lane select, conflict detect, read counters and output mux.
- Target size is roughly 200 RTL lines.

## Test plan
All scenarios use BitSize=8, NumberOfK=4, ProcessingElements=2, OutWidth=2.

- Basic: write kernel k, pixel p with value 16k+p, pairing kernels {0,1} then {2,3}, with out_ready=1 throughout. Expect 16 outputs 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33. out_channel steps 0..3, out_last only on 0x33, out_done one cycle later, out_error=0.
- Backpressure: same fill, with out_ready toggling 1,0,0,1. Expect identical sequence, out_data held during stalls, and 16 transfers total.
- Lane conflict: in_valid=4'b0101 in a single cycle. Expect out_error=1 on the next cycle, remaining sticky.
- Overflow: five writes to kernel 0. Expect out_error=1, and kernel 0 drains its first four values only.
- Writes during DRAIN: in_valid=4'b0001 while in_ready=0. Expect out_error=1 and drained data unchanged.
- Reset mid-drain: assert res after 5 transfers. Expect out_valid=0, in_ready=1 immediately. A subsequent full refill drains correctly from channel 0, pixel 0.

Source files
------------

// File: rtl/pms_pkg.sv
// Shared types for the pooled map serializer: FSM state encoding and pointer sizing.
package pms_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } pms_state_e;

    // Pointers must be able to hold Depth itself, which marks a bank as full.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pooled_map_serializer_if.sv
// Pixel ingress (per-kernel strobes on shared lanes) and serialized map egress.
interface pooled_map_serializer_if #(
    parameter int BitSize            = 32,
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    localparam int CW                = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
);
    logic [NumberOfK-1:0]                   in_valid;
    logic [ProcessingElements*BitSize-1:0]  in_data;
    logic                                   in_ready;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [BitSize-1:0]                     out_data;
    logic [CW-1:0]                          out_channel;
    logic                                   out_last;
    logic                                   out_done;
    logic                                   out_error;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_last, out_done, out_error
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_last, out_done, out_error
    );
endinterface

// File: rtl/map_bank.sv
// One kernel's feature map: write-pointer-addressed storage with an asynchronous read port.
module map_bank
    import pms_pkg::*;
#(
    parameter int BitSize  = 32,
    parameter int Depth    = 4,
    localparam int PW      = ptr_width(Depth),
    localparam int AW      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic               clk,
    input  logic               res,
    input  logic               wr_en,
    input  logic [BitSize-1:0] wr_data,
    input  logic               clr,
    input  logic [AW-1:0]      rd_addr,
    output logic [BitSize-1:0] rd_data,
    output logic               full_next,
    output logic               overflow
);
    logic [BitSize-1:0] mem [Depth];
    logic [PW-1:0]      wr_ptr;
    logic               full;
    logic               wr_ok;

    assign full      = (wr_ptr == PW'(Depth));
    assign wr_ok     = wr_en && !full;
    assign overflow  = wr_en && full;
    // Lets the top leave COLLECT on the same edge as the final write.
    assign full_next = full || (wr_en && (wr_ptr == PW'(Depth - 1)));
    assign rd_data   = mem[rd_addr];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (wr_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Storage is deliberately not reset; stale maps are overwritten on refill.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/pooled_map_serializer.sv
// Collects one pooled map per kernel, then streams all maps channel-major, raster order.
//   state   | meaning
//   COLLECT | banks accept per-kernel writes until every bank holds Depth words
//   DRAIN   | banks read out as a valid/ready stream; last transfer returns to COLLECT
module pooled_map_serializer
    import pms_pkg::*;
#(
    parameter int BitSize            = 32,
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int OutWidth           = 2
) (
    input  logic                     clk,
    input  logic                     res,
    pooled_map_serializer_if.slave   bus
);
    localparam int Depth = OutWidth * OutWidth;
    localparam int PW    = ptr_width(Depth);
    localparam int AW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW    = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;

    pms_state_e state, state_nxt;

    logic [NumberOfK-1:0] wr_en;
    logic [NumberOfK-1:0] full_next;
    logic [NumberOfK-1:0] overflow;
    logic [BitSize-1:0]   rd_data [NumberOfK];
    logic [PW-1:0]        rd_px;
    logic [CW-1:0]        rd_ch;
    logic                 collect;
    logic                 lane_conflict;
    logic                 xfer;
    logic                 last;
    logic                 done_nxt;
    logic                 done_q;
    logic                 error_q;

    assign collect = (state == COLLECT);
    assign wr_en   = bus.in_valid & {NumberOfK{collect}};
    assign xfer    = !collect && bus.out_ready;
    assign last    = !collect && (rd_ch == CW'(NumberOfK - 1)) && (rd_px == PW'(Depth - 1));

    for (genvar k = 0; k < NumberOfK; k++) begin : g_bank
        map_bank #(
            .BitSize (BitSize),
            .Depth   (Depth)
        ) u_bank (
            .clk       (clk),
            .res       (res),
            .wr_en     (wr_en[k]),
            .wr_data   (bus.in_data[(k % ProcessingElements)*BitSize +: BitSize]),
            .clr       (xfer && last),
            .rd_addr   (rd_px[AW-1:0]),
            .rd_data   (rd_data[k]),
            .full_next (full_next[k]),
            .overflow  (overflow[k])
        );
    end

    // Two strobes on kernels sharing a lane means the producer overlapped them.
    always_comb begin
        lane_conflict = 1'b0;
        for (int i = 0; i < NumberOfK; i++) begin
            for (int j = i + 1; j < NumberOfK; j++) begin
                if (((i % ProcessingElements) == (j % ProcessingElements)) &&
                    bus.in_valid[i] && bus.in_valid[j]) begin
                    lane_conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            COLLECT: if (&full_next) state_nxt = DRAIN;
            DRAIN: begin
                if (xfer && last) begin
                    state_nxt = COLLECT;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= COLLECT;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= done_nxt;
            error_q <= error_q || (collect && lane_conflict) || (|overflow) ||
                       (!collect && (|bus.in_valid));
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rd_px <= '0;
            rd_ch <= '0;
        end else if (xfer && last) begin
            rd_px <= '0;
            rd_ch <= '0;
        end else if (xfer) begin
            if (rd_px == PW'(Depth - 1)) begin
                rd_px <= '0;
                rd_ch <= rd_ch + CW'(1);
            end else begin
                rd_px <= rd_px + PW'(1);
            end
        end
    end

    assign bus.in_ready    = collect;
    assign bus.out_valid   = !collect;
    assign bus.out_data    = collect ? '0 : rd_data[rd_ch];
    assign bus.out_channel = rd_ch;
    assign bus.out_last    = last;
    assign bus.out_done    = done_q;
    assign bus.out_error   = error_q;
endmodule

// File: tb/tb_pooled_map_serializer.sv
// Randomized and directed bench for pooled_map_serializer against a queue-based map model.
module tb_pooled_map_serializer;
    import pms_pkg::*;

    localparam int BW = 8;
    localparam int NK = 4;
    localparam int PE = 2;
    localparam int OW = 2;
    localparam int DP = OW * OW;
    localparam int TOTAL = NK * DP;

    logic clk = 1'b0;
    logic res = 1'b0;

    pooled_map_serializer_if #(.BitSize(BW), .NumberOfK(NK), .ProcessingElements(PE)) bus ();

    pooled_map_serializer #(
        .BitSize(BW), .NumberOfK(NK), .ProcessingElements(PE), .OutWidth(OW)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [BW-1:0] ref_q [NK][$];
    bit            ref_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NK; k++) ref_q[k].delete();
        ref_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        res = 1'b0;
        model_clear();
    endtask

    // One write cycle: drive at negedge, DUT samples at posedge, return at next negedge.
    task automatic write_cycle(input logic [NK-1:0] v, input logic [BW-1:0] d0, input logic [BW-1:0] d1);
        logic [BW-1:0] lane [PE];
        lane[0] = d0;
        lane[1] = d1;
        for (int i = 0; i < NK; i++)
            for (int j = i + 1; j < NK; j++)
                if ((i % PE) == (j % PE) && v[i] && v[j]) ref_err = 1'b1;
        for (int k = 0; k < NK; k++) begin
            if (v[k]) begin
                if (ref_q[k].size() < DP) ref_q[k].push_back(lane[k % PE]);
                else ref_err = 1'b1;
            end
        end
        bus.in_valid = v;
        bus.in_data  = {d1, d0};
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = '0;
    endtask

    function automatic bit all_full();
        for (int k = 0; k < NK; k++) if (ref_q[k].size() < DP) return 1'b0;
        return 1'b1;
    endfunction

    // Fill whatever is left with random data, one kernel per lane per cycle, no conflicts.
    task automatic fill_random();
        int guard = 0;
        while (!all_full() && guard < 200) begin
            logic [NK-1:0] v = '0;
            for (int l = 0; l < PE; l++) begin
                int pick = $urandom_range(0, 2);
                if (pick == 0 && ref_q[l].size() < DP) v[l] = 1'b1;
                else if (pick == 1 && ref_q[l + PE].size() < DP) v[l + PE] = 1'b1;
            end
            write_cycle(v, BW'($urandom), BW'($urandom));
            guard++;
        end
        chk("fill_budget", 32'(all_full()), 32'd1);
    endtask

    task automatic fill_basic();
        for (int p = 0; p < DP; p++) write_cycle(4'b0011, BW'(p), BW'(16 + p));
        for (int p = 0; p < DP; p++) write_cycle(4'b1100, BW'(32 + p), BW'(48 + p));
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic drain(input int mode, input int abort_at, input bit inject);
        logic [BW-1:0] exp [TOTAL];
        logic [3:0]    pat = 4'b1001;
        int idx = 0;
        int cyc = 0;
        bit injected = 1'b0;
        for (int c = 0; c < NK; c++)
            for (int p = 0; p < DP; p++) exp[c*DP + p] = ref_q[c][p];
        chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
        while (idx < TOTAL && cyc < 400) begin
            if (abort_at > 0 && idx == abort_at) break;
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", 32'(bus.out_data), 32'(exp[idx]));
            chk("out_channel", 32'(bus.out_channel), 32'(idx / DP));
            chk("out_last", 32'(bus.out_last), 32'(idx == TOTAL - 1));
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = pat[cyc % 4];
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && !injected && idx == 3) begin
                bus.in_valid = 4'b0001;
                bus.in_data  = {BW'($urandom), BW'($urandom)};
                injected = 1'b1;
                ref_err = 1'b1;
            end
            @(posedge clk);
            if (bus.out_ready) idx++;
            @(negedge clk);
            bus.in_valid  = '0;
            bus.out_ready = 1'b0;
            cyc++;
        end
        if (cyc >= 400) chk("drain_budget", 32'(idx), 32'(TOTAL));
        if (abort_at == 0) begin
            chk("done_valid", 32'(bus.out_valid), 32'd0);
            chk("done_pulse", 32'(bus.out_done), 32'd1);
            chk("done_in_ready", 32'(bus.in_ready), 32'd1);
            chk("out_error", 32'(bus.out_error), 32'(ref_err));
            for (int k = 0; k < NK; k++) ref_q[k].delete();
            @(negedge clk);
            chk("done_clear", 32'(bus.out_done), 32'd0);
        end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        do_reset();

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_done", 32'(bus.out_done), 32'd0);
        chk("rst_out_error", 32'(bus.out_error), 32'd0);
        chk("rst_out_channel", 32'(bus.out_channel), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);

        // Basic and backpressure with the 16k+p pattern.
        fill_basic();
        drain(0, 0, 1'b0);
        fill_basic();
        drain(1, 0, 1'b0);

        // Random maps and random backpressure.
        for (int r = 0; r < 4; r++) begin
            fill_random();
            drain(2, 0, 1'b0);
        end

        // Write attempt while draining.
        fill_random();
        drain(2, 0, 1'b1);

        // Lane conflict: kernels 0 and 2 both take lane 0 data.
        do_reset();
        write_cycle(4'b0101, 8'hA5, 8'h5A);
        chk("conflict_err", 32'(bus.out_error), 32'd1);
        fill_random();
        drain(2, 0, 1'b0);
        chk("conflict_sticky", 32'(bus.out_error), 32'd1);

        // Overflow: fifth write to kernel 0 is dropped.
        do_reset();
        for (int p = 0; p < DP + 1; p++) write_cycle(4'b0001, BW'(8'hC0 + p), 8'h00);
        chk("ovf_err", 32'(bus.out_error), 32'd1);
        fill_random();
        drain(0, 0, 1'b0);

        // Reset mid-drain, then a clean refill.
        do_reset();
        fill_random();
        drain(0, 5, 1'b0);
        res = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        res = 1'b0;
        model_clear();
        fill_random();
        drain(1, 0, 1'b0);
        chk("final_error", 32'(bus.out_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
